// File: rtl/cdb_pkg.sv
// cdb_pkg: shared CDB widths, broadcast payload type and unit-index width helper.
package cdb_pkg;
    localparam int CDB_DATA_W = 16;
    localparam int CDB_TAG_W  = 3;
    localparam int CDB_POS_W  = 2;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_POS_W-1:0]  pos;
        logic [CDB_DATA_W-1:0] data;
    } cdb_payload_t;

    function automatic int unit_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cdb_unit_fifo.sv
// cdb_unit_fifo: per-unit result FIFO with explicit count, flush and async active-low reset.
module cdb_unit_fifo import cdb_pkg::*; #(
    parameter int W     = 21,
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd, wr;

    assign head = mem[rd];

    always_ff @(posedge clock)
        if (push && !flush) mem[wr] <= din;

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
endmodule

// File: rtl/cdb_arbiter_rr.sv
// cdb_arbiter_rr: round-robin CDB arbiter over N_UNITS buffered result producers.
// Define CDB_BYPASS_EN to let an empty unit's live input win and broadcast with 1-cycle latency.
module cdb_arbiter_rr import cdb_pkg::*; #(
    parameter int N_UNITS    = 2,
    parameter int DATA_W     = CDB_DATA_W,
    parameter int TAG_W      = CDB_TAG_W,
    parameter int POS_W      = CDB_POS_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [N_UNITS-1:0]             fu_valid,
    output logic [N_UNITS-1:0]             fu_ready,
    input  logic [N_UNITS*TAG_W-1:0]       fu_tag,
    input  logic [N_UNITS*POS_W-1:0]       fu_pos,
    input  logic [N_UNITS*DATA_W-1:0]      fu_data,
    output logic                           cdb_valid,
    output logic [unit_idx_w(N_UNITS)-1:0] cdb_unit,
    output logic [TAG_W-1:0]               cdb_tag,
    output logic [POS_W-1:0]               cdb_pos,
    output logic [DATA_W-1:0]              cdb_data
);
    localparam int UW = unit_idx_w(N_UNITS);
    localparam int PW = TAG_W + POS_W + DATA_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0]      count [N_UNITS];
    logic [PW-1:0]      head  [N_UNITS];
    logic [PW-1:0]      din   [N_UNITS];
    logic [N_UNITS-1:0] cand, push, pop;
    logic [UW-1:0]      rr_ptr, win, nxt;
    logic [PW-1:0]      sel;
    logic               found;

    for (genvar i = 0; i < N_UNITS; i++) begin : g_unit
        assign din[i]      = {fu_tag[i*TAG_W +: TAG_W], fu_pos[i*POS_W +: POS_W], fu_data[i*DATA_W +: DATA_W]};
        assign fu_ready[i] = (count[i] != CW'(FIFO_DEPTH)) && !flush;
        assign pop[i]      = found && (win == UW'(i)) && (count[i] != '0) && !flush;
`ifdef CDB_BYPASS_EN
        assign cand[i] = (count[i] != '0) || (fu_valid[i] && fu_ready[i]);
        assign push[i] = fu_valid[i] && fu_ready[i] && !(found && (win == UW'(i)) && (count[i] == '0));
`else
        assign cand[i] = count[i] != '0;
        assign push[i] = fu_valid[i] && fu_ready[i];
`endif
        cdb_unit_fifo #(.W(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clock(clock),
            .reset(reset),
            .flush(flush),
            .push(push[i]),
            .pop(pop[i]),
            .din(din[i]),
            .head(head[i]),
            .count(count[i])
        );
    end

    // scan offsets high to low so the candidate nearest rr_ptr is the last assignment
    always_comb begin
        found = 1'b0;
        win = '0;
        for (int k = N_UNITS - 1; k >= 0; k--) begin
            if (cand[(int'(rr_ptr) + k) % N_UNITS]) begin
                found = 1'b1;
                win = UW'((int'(rr_ptr) + k) % N_UNITS);
            end
        end
    end

    assign nxt = (win == UW'(N_UNITS - 1)) ? '0 : win + 1'b1;
    assign sel = (count[win] != '0) ? head[win] : din[win];

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_unit  <= '0;
            {cdb_tag, cdb_pos, cdb_data} <= '0;
        end else if (flush) begin
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_unit  <= '0;
            {cdb_tag, cdb_pos, cdb_data} <= '0;
        end else begin
            cdb_valid <= found;
            cdb_unit  <= found ? win : '0;
            {cdb_tag, cdb_pos, cdb_data} <= found ? sel : '0;
            if (found) rr_ptr <= nxt;
        end
endmodule

// File: tb/tb_cdb_arbiter_rr.sv
// tb_cdb_arbiter_rr: directed checks of handshake, round-robin order, flush, async reset and latency.
module tb_cdb_arbiter_rr;
    localparam int N  = 3;
    localparam int DW = 16;
    localparam int TW = 3;
    localparam int PW = 2;
`ifdef CDB_BYPASS_EN
    localparam int L = 1;
`else
    localparam int L = 2;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic [N-1:0]  fu_valid = '0;
    logic [N-1:0]  fu_ready;
    logic [N*TW-1:0] fu_tag = '0;
    logic [N*PW-1:0] fu_pos = '0;
    logic [N*DW-1:0] fu_data = '0;
    logic          cdb_valid;
    logic [1:0]    cdb_unit;
    logic [TW-1:0] cdb_tag;
    logic [PW-1:0] cdb_pos;
    logic [DW-1:0] cdb_data;

    int errs = 0;
    int checks = 0;

    cdb_arbiter_rr #(.N_UNITS(N), .DATA_W(DW), .TAG_W(TW), .POS_W(PW), .FIFO_DEPTH(2)) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .fu_valid(fu_valid),
        .fu_ready(fu_ready),
        .fu_tag(fu_tag),
        .fu_pos(fu_pos),
        .fu_data(fu_data),
        .cdb_valid(cdb_valid),
        .cdb_unit(cdb_unit),
        .cdb_tag(cdb_tag),
        .cdb_pos(cdb_pos),
        .cdb_data(cdb_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int u, input logic v, input logic [TW-1:0] t, input logic [PW-1:0] p, input logic [DW-1:0] d);
        fu_valid[u] = v;
        fu_tag[u*TW +: TW] = t;
        fu_pos[u*PW +: PW] = p;
        fu_data[u*DW +: DW] = d;
    endtask

    task automatic exp_cdb(input string tag, input int u, input int t, input int p, input int d);
        chk({tag, ".valid"}, cdb_valid, 1);
        chk({tag, ".unit"}, cdb_unit, u);
        chk({tag, ".tag"}, cdb_tag, t);
        chk({tag, ".pos"}, cdb_pos, p);
        chk({tag, ".data"}, cdb_data, d);
    endtask

    task automatic do_flush(input string tag);
        flush = 1'b1;
        #1;
        chk({tag, ".ready_in_flush"}, fu_ready, 0);
        tick;
        flush = 1'b0;
        #1;
        chk({tag, ".valid_after"}, cdb_valid, 0);
        chk({tag, ".ready_after"}, fu_ready, 7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] seq [3];
        int idx, got, u;
        logic acc, saw_full;

        // reset state
        #12;
        chk("rst.valid", cdb_valid, 0);
        chk("rst.unit", cdb_unit, 0);
        chk("rst.data", cdb_data, 0);
        chk("rst.ready", fu_ready, 7);
        reset = 1'b1;
        #4;

        // single result latency
        drive(0, 1, 1, 2, 16'h0055);
        tick;
        drive(0, 0, 0, 0, 0);
        chk("t1.early", cdb_valid, 32'(L == 1));
        repeat (L - 1) tick;
        exp_cdb("t1", 0, 1, 2, 'h55);
        tick;
        chk("t1.done", cdb_valid, 0);
        do_flush("f0");

        // three units continuously valid: fair rotation 0,1,2,0,1,2
        for (int i = 0; i < N; i++) drive(i, 1, 3'(i), 2'(i), 16'(16'h10 + i));
        for (int k = 0; k <= L + 4; k++) begin
            tick;
            if (k == 5) fu_valid = '0;
            if (k >= L - 1) begin
                u = (k - L + 1) % 3;
                exp_cdb($sformatf("t2.g%0d", k - L + 1), u, u, u, 16'h10 + u);
            end
        end
        do_flush("f1");

        // flush with buffered entries, then rr restarts at unit0
        drive(1, 1, 1, 1, 16'h0041);
        drive(2, 1, 2, 2, 16'h0042);
        tick;
        tick;
        fu_valid = '0;
        do_flush("t4");
        tick;
        chk("t4.no_stale", cdb_valid, 0);
        drive(1, 1, 5, 1, 16'h0051);
        drive(2, 1, 6, 2, 16'h0052);
        tick;
        fu_valid = '0;
        repeat (L - 1) tick;
        exp_cdb("t4.first", 1, 5, 1, 'h51);
        tick;
        exp_cdb("t4.second", 2, 6, 2, 'h52);
        tick;
        chk("t4.idle", cdb_valid, 0);

        // unit1 sends three results under contention; must fill, keep order, no loss
        seq[0] = 16'h00a1;
        seq[1] = 16'h00a2;
        seq[2] = 16'h00a3;
        idx = 0;
        got = 0;
        saw_full = 1'b0;
        drive(0, 1, 0, 0, 16'h0020);
        drive(2, 1, 2, 0, 16'h0022);
        drive(1, 1, 1, 3, seq[0]);
        for (int c = 0; c < 24; c++) begin
            @(negedge clock);
            acc = fu_valid[1] && fu_ready[1];
            if (!fu_ready[1]) saw_full = 1'b1;
            @(posedge clock);
            #1;
            if (acc) idx++;
            if (cdb_valid && cdb_unit == 2'd1) begin
                chk($sformatf("t3.order%0d", got), cdb_data, (got < 3) ? seq[got] : 16'hffff);
                got++;
            end
            if (idx < 3 && c < 12) drive(1, 1, 1, 3, seq[idx]);
            else fu_valid[1] = 1'b0;
            if (c >= 12) begin
                fu_valid[0] = 1'b0;
                fu_valid[2] = 1'b0;
            end
        end
        chk("t3.count", got, 3);
        chk("t3.saw_full", saw_full, 1);
        chk("t3.drained", cdb_valid, 0);

        // async reset while broadcasting
        drive(0, 1, 7, 3, 16'h0077);
        drive(1, 1, 4, 1, 16'h0078);
        tick;
        tick;
        chk("t5.pre", cdb_valid, 1);
        #3;
        reset = 1'b0;
        #1;
        chk("t5.valid", cdb_valid, 0);
        chk("t5.unit", cdb_unit, 0);
        chk("t5.tag", cdb_tag, 0);
        chk("t5.pos", cdb_pos, 0);
        chk("t5.data", cdb_data, 0);
        chk("t5.ready", fu_ready, 7);
        fu_valid = '0;
        #2;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk($sformatf("t5.quiet%0d", c), cdb_valid, 0);
        end

        // minimum latency from an empty FIFO with no competitors
        drive(2, 1, 6, 1, 16'h0066);
        tick;
        fu_valid = '0;
        chk("t6.k.valid", cdb_valid, 32'(L == 1));
        chk("t6.k.data", cdb_data, (L == 1) ? 32'h66 : 32'h0);
        tick;
        chk("t6.k1.valid", cdb_valid, 32'(L == 2));
        chk("t6.k1.data", cdb_data, (L == 2) ? 32'h66 : 32'h0);
        tick;
        chk("t6.done", cdb_valid, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
